// File: rtl/sub_serial.sv
// ----------------------------------------------------------------------------
// sub_serial
//
// Word-serial unsigned subtractor: D = (A - B - BI) mod 2^N, BO = borrow-out.
// The N-bit operands are consumed W bits per clock, least significant chunk
// first. The borrow between chunks travels through a register, so there is
// never a combinational path from one chunk to the next.
//
// Handshake: start is sampled only while idle. An accepted start latches A, B
// and BI. busy is high for the K = N/W cycles of the operation. done is a
// one-cycle pulse in the cycle after the last chunk, and D/BO are valid from
// then on. D and BO hold until the next operation completes. A start that
// arrives while busy is dropped; requests are not queued.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active low
//   start        operation request (sampled in IDLE only)
//   A, B         N-bit minuend / subtrahend (sampled on accepted start)
//   BI           borrow-in (sampled on accepted start)
//   busy         high while chunks are being processed
//   done         one-cycle completion pulse
//   D            N-bit difference, held until the next completion
//   BO           borrow-out, held until the next completion
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RUN)
// ----------------------------------------------------------------------------
module sub_serial #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         BI,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D,
    output logic         BO,
    output logic         dbg_state_o
);

    localparam int K  = N / W;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    // Elaboration-time parameter check.
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_param_check
        $error("sub_serial: N must be a multiple of W and 1 <= W <= N");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           borrow_q, borrow_d;
    logic           bo_q, bo_d;
    logic           done_q, done_d;

    // Chunk arithmetic: a - b - borrow computed as a + ~b + ~borrow.
    // A carry-out of 1 means the chunk did not need to borrow.
    logic [W:0]     chunk_sum;
    logic           borrow_nxt;
    logic [N-1:0]   r_shift;
    logic           last_chunk;

    assign chunk_sum  = {1'b0, a_q[W-1:0]} + {1'b0, ~b_q[W-1:0]} + {{W{1'b0}}, ~borrow_q};
    assign borrow_nxt = ~chunk_sum[W];
    assign last_chunk = (cnt_q == CW'(K - 1));

    // New chunk enters at the top; after K shifts chunk 0 sits at the bottom.
    if (W == N) begin : g_single_chunk
        assign r_shift = chunk_sum[W-1:0];
    end else begin : g_multi_chunk
        assign r_shift = {chunk_sum[W-1:0], r_q[N-1:W]};
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (last_chunk) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = BI;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                a_d      = a_q >> W;
                b_d      = b_q >> W;
                r_d      = r_shift;
                borrow_d = borrow_nxt;
                if (last_chunk) begin
                    // D is written in one go so it never mixes old and new chunks.
                    d_d    = r_shift;
                    bo_d   = borrow_nxt;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            done_q   <= done_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign D           = d_q;
    assign BO          = bo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_serial.sv
// ----------------------------------------------------------------------------
// tb_sub_serial: directed bench for sub_serial (N=32, W=8, so K=4).
// Inputs change #1 after a rising edge; outputs are observed at the same point.
// ----------------------------------------------------------------------------
module tb_sub_serial;

    localparam int N = 32;
    localparam int W = 8;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         BI;
    logic         busy;
    logic         done;
    logic [N-1:0] D;
    logic         BO;
    logic         dbg_state;

    int errors = 0;
    int checks = 0;

    sub_serial #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .BI          (BI),
        .busy        (busy),
        .done        (done),
        .D           (D),
        .BO          (BO),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver / scenarios ----------------
    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        BI    = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, D, BO, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b D=%h BO=%b st=%b, want all zero",
                     busy, done, D, BO, dbg_state);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    // One full operation: latency, busy window, result, done pulse width.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                          input logic [N-1:0] exp_d, input logic exp_bo, input string name);
        int lat;
        int busy_cnt;
        int overlap;
        A = a; B = b; BI = bi; start = 1'b1;
        tick();
        start = 1'b0;
        // Operands are don't-care after the accepted edge.
        A = $urandom; B = $urandom; BI = 1'($urandom_range(0, 1));
        lat = 0;
        busy_cnt = 0;
        overlap = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        if (done === 1'b1 && busy === 1'b1) overlap = 1;
        checks++;
        if (lat !== K) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want %0d", name, lat, K);
        end
        checks++;
        if (busy_cnt !== K || overlap !== 0) begin
            errors++;
            $display("FAIL %s_busy: busy cycles %0d overlap %0d, want %0d and 0",
                     name, busy_cnt, overlap, K);
        end
        checks++;
        if (D !== exp_d || BO !== exp_bo) begin
            errors++;
            $display("FAIL %s_result: D=%h BO=%b, want D=%h BO=%b", name, D, BO, exp_d, exp_bo);
        end
        tick();
        checks++;
        if (done !== 1'b0 || D !== exp_d || BO !== exp_bo) begin
            errors++;
            $display("FAIL %s_hold: done=%b D=%h BO=%b, want done=0 D=%h BO=%b",
                     name, done, D, BO, exp_d, exp_bo);
        end
    endtask

    task automatic test_basic();
        run_op(32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000, 1'b0, "basic");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, "ripple_all");
        run_op(32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, "borrow_in_cross");
        run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, "max_sub");
        run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, "equal");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, "top_chunk");
    endtask

    task automatic test_start_while_busy();
        int n_done;
        int done_at;
        logic [N-1:0] got_d;
        logic got_bo;
        A = 32'd5; B = 32'd3; BI = 1'b0; start = 1'b1;
        tick();                               // edge t: accepted
        start = 1'b0;
        tick();                               // edge t+1
        A = 32'd9; B = 32'd9; BI = 1'b0; start = 1'b1;
        tick();                               // edge t+2: must be ignored
        start = 1'b0;
        n_done = 0;
        done_at = -1;
        got_d = '0;
        got_bo = 1'b0;
        for (int e = 3; e <= 12; e++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                done_at = e;
                got_d = D;
                got_bo = BO;
            end
        end
        checks++;
        if (n_done !== 1 || done_at !== K) begin
            errors++;
            $display("FAIL ignore_busy_done: %0d pulses, last at edge %0d, want 1 at %0d",
                     n_done, done_at, K);
        end
        checks++;
        if (got_d !== 32'd2 || got_bo !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_result: D=%h BO=%b, want 00000002 0", got_d, got_bo);
        end
    endtask

    task automatic test_mid_reset();
        int n_done;
        A = 32'h55; B = 32'h11; BI = 1'b0; start = 1'b1;
        tick();                               // edge t: accepted
        start = 1'b0;
        tick();                               // edge t+1
        rst = 1'b0;
        tick();                               // edge t+2: reset
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || BO !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b D=%h BO=%b, want 0 0 0 0",
                     busy, done, D, BO);
        end
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 2 * K; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL mid_reset_quiet: %0d cycles with done/busy, want 0", n_done);
        end
        run_op(32'd7, 32'd7, 1'b1, 32'hFFFF_FFFF, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back();
        int wait_cnt;
        int gap;
        A = 32'h0000_1000; B = 32'd1; BI = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_cnt = 0;
        while (done !== 1'b1 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (done !== 1'b1 || D !== 32'h0000_0FFF || BO !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: done=%b D=%h BO=%b, want 1 00000fff 0", done, D, BO);
        end
        // Second request raised in the done cycle; it is accepted on the next
        // edge, so its done lands K edges later (K+1 after the first done).
        A = 32'd3; B = 32'd5; BI = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        gap = 1;
        while (done !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        checks++;
        if (gap !== K + 1) begin
            errors++;
            $display("FAIL b2b_spacing: done gap %0d edges, want %0d (start latency %0d)",
                     gap, K + 1, K);
        end
        checks++;
        if (D !== 32'hFFFF_FFFE || BO !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: D=%h BO=%b, want fffffffe 1", D, BO);
        end
        tick();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
